image_crop: RTL and testbench
=============================

# image_crop

Streaming region-of-interest crop stage that sits directly downstream of the imager receive stage. It consumes the `dvi`/`dtypei`/`datai` image stream (`DTYPE_*` from `dtypes.v`) and forwards only the pixels, and the row markers, that fall inside a programmable window. It renumbers the forwarded rows and passes frame markers and header words unchanged. Window configuration is shadowed at each frame start, so register writes never tear a frame.

## Interface
- `DATA_WIDTH`, 16: stream data width.
- `DIM_WIDTH`, 16: row/column counter and window field width.

- `clk` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: 1 = crop, 0 = bypass; sampled at FRAME_START.
- `win_col_start` in DIM_WIDTH: first input column kept.
- `win_row_start` in DIM_WIDTH: first input row kept.
- `win_num_cols` in DIM_WIDTH: window width; 0 = no pixels.
- `win_num_rows` in DIM_WIDTH: window height; 0 = no rows.
- `dvi` in 1: input data valid.
- `dtypei` in `DTYPE_WIDTH`: input data type.
- `datai` in DATA_WIDTH: input data.
- `dvo` out 1: output data valid.
- `dtypeo` out `DTYPE_WIDTH`: output data type.
- `datao` out DATA_WIDTH: output data.
- `rows_out` out DIM_WIDTH: rows forwarded in the last completed frame.
- `cols_out` out DIM_WIDTH: pixels forwarded in the last forwarded row of the last completed frame.

## Operation
- **States:**
  - IDLE (reset state): drops PIXEL, ROW_START, ROW_END and FRAME_END. Forwards HEADER_START, HEADER and HEADER_END unchanged. FRAME_START is forwarded and moves the block to ACTIVE.
  - ACTIVE: FRAME_END is forwarded and moves the block to IDLE. A FRAME_START seen in ACTIVE is forwarded and restarts the frame; the block stays in ACTIVE.
- **At FRAME_START:**
  - Latch `enable` and all four `win_*` inputs into shadow registers.
  - Clear `row_cnt`, `col_cnt` and the forwarded-row/column tallies.
  - `datao` is passed through (frame count).
- **Counters (ACTIVE):**
  - `col_cnt` clears on ROW_START and increments on each PIXEL.
  - `row_cnt` increments on each ROW_END.
  - Both counters saturate at all-ones and never wrap.
- **Window tests:**
  - `row_in = row_cnt >= row_start && row_cnt < row_start + num_rows`.
  - `col_in` is the same test applied to `col_cnt`, `col_start` and `num_cols`.
  - Sums are computed at DIM_WIDTH+1 bits, so a window that runs past the counter range never aliases.
- **Filtering when the shadow enable is 1:**
  - PIXEL is forwarded iff `row_in && col_in`.
  - ROW_START is forwarded iff `row_in`, with `datao = row_cnt - row_start`.
  - ROW_END is forwarded iff `row_in`, with `datao = 0`.
- **Bypass:** when the shadow enable is 0, every word in ACTIVE is forwarded unchanged. The IDLE filtering rules still apply.
- **Other words:** header words and unrecognised dtypes are forwarded unchanged in both states.
- **Missing markers:** upstream may omit the first ROW_START (trumped by FRAME_START) and the last ROW_END (trumped by FRAME_END).
  - A missing ROW_START is treated as row 0 with `col_cnt` = 0, because FRAME_START cleared it.
  - No marker is ever synthesised. If the window includes row 0, the missing ROW_START is simply absent downstream too.
- **Status outputs:**
  - Per forwarded row: count the forwarded pixels.
  - At each forwarded ROW_END: increment the row tally and capture the pixel count.
  - At FRAME_END in ACTIVE: `rows_out` and `cols_out` update from the tallies. They hold their value otherwise.
  - In bypass, the tallies count every row and pixel.

## Timing
- Latency: exactly 1 cycle, and all outputs are registered.
- Every input word with `dvi=1` produces, in the next cycle, either the output word or `dvo=0`.
- Idle cycles: `dvi=0` gives `dvo=0`, `dtypeo=0` and `datao=0` on the next cycle. A dropped word gives the same result.
- Throughput: 1 word per cycle. No backpressure; the block never stalls.
- Reset values: `dvo=0`, `dtypeo=0`, `datao=0`, `rows_out=0`, `cols_out=0`; state IDLE; counters and shadows 0.
- Reset mid-frame: outputs are zero on the next cycle and the block remains in IDLE. The rest of that frame is dropped except header words, and cropping resumes at the next FRAME_START.
- `win_*` or `enable` changes mid-frame have no effect until the next FRAME_START.
- A window that starts beyond the frame forwards the frame markers and no rows or pixels; the next FRAME_END then sets `rows_out=0`.

## Test plan
- **Basic crop:** 8x6 frame, window col 2, row 1, 4x3.
  - Per frame: 3 ROW_START with `datao` 0, 1, 2; 12 PIXELs, namely columns 2..5 of input rows 1..3; 3 ROW_END.
  - At FRAME_END: `rows_out=3`, `cols_out=4`.
  - FRAME_START `datao` is unchanged.
- **Bypass:** `enable=0`, same frame.
  - Output equals input delayed 1 cycle, word for word.
  - At FRAME_END: `rows_out=6`, `cols_out=8`.
- **Mid-frame reprogram:** change the window to 0, 0, 2x2 during row 3.
  - The current frame still uses 2, 1, 4x3.
  - The next frame yields 4 pixels.
- **Reset during row 2:** assert `reset` for 1 cycle.
  - `dvo=0` on the next cycle.
  - Remaining pixels and the FRAME_END are dropped; header words pass.
  - The next frame crops correctly.
- **Edges and overflow:**
  - Window 0, 0, 0x0: only FRAME_START, FRAME_END and header words appear.
  - Window `col_start=16'hFFFE`, `num_cols=16'h0004`: no wrap-around pixels from column 0.
- **Missing first ROW_START:** FRAME_START with no ROW_START, followed by 8 pixels, with the window covering row 0.
  - Pixels are forwarded and no ROW_START is synthesised.
  - The next row's ROW_START has `datao=1`.

Source files
------------

// File: rtl/image_crop_if.sv
`default_nettype none
// =============================================================================
// Module   : image_crop_if
// Brief    : Image stream bundle: input word (dvi/dtypei/datai) and the
//            registered output word (dvo/dtypeo/datao) of a stream stage.
// Revision : 1.0 - initial release
// =============================================================================
interface image_crop_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int DTYPE_WIDTH = 4
);
    logic                   dvi;
    logic [DTYPE_WIDTH-1:0] dtypei;
    logic [DATA_WIDTH-1:0]  datai;
    logic                   dvo;
    logic [DTYPE_WIDTH-1:0] dtypeo;
    logic [DATA_WIDTH-1:0]  datao;

    // master is the environment (source and sink), slave is the stream stage
    modport master (
        output dvi,
        output dtypei,
        output datai,
        input  dvo,
        input  dtypeo,
        input  datao
    );

    modport slave (
        input  dvi,
        input  dtypei,
        input  datai,
        output dvo,
        output dtypeo,
        output datao
    );
endinterface
`default_nettype wire

// File: rtl/image_crop.sv
`default_nettype none
// =============================================================================
// Module   : image_crop
// Brief    : Streaming region-of-interest crop with frame-shadowed window,
//            row renumbering and per-frame row/column status.
// Revision : 1.0 - initial release
// =============================================================================
module image_crop #(
    parameter int DATA_WIDTH = 16,
    parameter int DIM_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DIM_WIDTH-1:0] win_col_start,
    input  logic [DIM_WIDTH-1:0] win_row_start,
    input  logic [DIM_WIDTH-1:0] win_num_cols,
    input  logic [DIM_WIDTH-1:0] win_num_rows,
    image_crop_if.slave          strm,
    output logic [DIM_WIDTH-1:0] rows_out,
    output logic [DIM_WIDTH-1:0] cols_out
);

    localparam int DTYPE_WIDTH = 4;

    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START  = 4'd1;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END    = 4'd2;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START    = 4'd3;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END      = 4'd4;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL        = 4'd5;

    localparam logic [DIM_WIDTH-1:0]   DIM_MAX = '1;
    localparam logic [DIM_WIDTH-1:0]   DIM_ONE = DIM_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                 state;
    state_t                 next_state;

    // Window shadows, loaded only at FRAME_START
    logic                   sh_enable;
    logic [DIM_WIDTH-1:0]   sh_col_start;
    logic [DIM_WIDTH-1:0]   sh_row_start;
    logic [DIM_WIDTH-1:0]   sh_num_cols;
    logic [DIM_WIDTH-1:0]   sh_num_rows;

    logic [DIM_WIDTH-1:0]   row_cnt;
    logic [DIM_WIDTH-1:0]   col_cnt;
    logic [DIM_WIDTH-1:0]   pix_tally;
    logic [DIM_WIDTH-1:0]   row_tally;
    logic [DIM_WIDTH-1:0]   last_cols;

    logic                   out_valid;
    logic [DTYPE_WIDTH-1:0] out_dtype;
    logic [DATA_WIDTH-1:0]  out_data;

    logic [DIM_WIDTH:0]     row_limit;
    logic [DIM_WIDTH:0]     col_limit;
    logic [DIM_WIDTH-1:0]   row_rel;
    logic                   row_in;
    logic                   col_in;

    logic                   fwd;
    logic [DATA_WIDTH-1:0]  fwd_data;
    logic                   frame_restart;
    logic                   frame_close;
    logic                   row_open;
    logic                   row_close;
    logic                   pixel_seen;

    // One extra bit keeps start+size from wrapping back into low coordinates
    assign row_limit = {1'b0, sh_row_start} + {1'b0, sh_num_rows};
    assign col_limit = {1'b0, sh_col_start} + {1'b0, sh_num_cols};
    assign row_in    = (row_cnt >= sh_row_start) && ({1'b0, row_cnt} < row_limit);
    assign col_in    = (col_cnt >= sh_col_start) && ({1'b0, col_cnt} < col_limit);
    assign row_rel   = row_cnt - sh_row_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        fwd           = 1'b0;
        fwd_data      = strm.datai;
        frame_restart = 1'b0;
        frame_close   = 1'b0;
        row_open      = 1'b0;
        row_close     = 1'b0;
        pixel_seen    = 1'b0;

        if (strm.dvi) begin
            case (strm.dtypei)
                DTYPE_FRAME_START: begin
                    fwd           = 1'b1;
                    frame_restart = 1'b1;
                    next_state    = ST_ACTIVE;
                end
                DTYPE_FRAME_END: begin
                    if (state == ST_ACTIVE) begin
                        fwd         = 1'b1;
                        frame_close = 1'b1;
                        next_state  = ST_IDLE;
                    end
                end
                DTYPE_ROW_START: begin
                    if (state == ST_ACTIVE) begin
                        row_open = 1'b1;
                        fwd      = !sh_enable || row_in;
                        if (sh_enable) begin
                            fwd_data = DATA_WIDTH'(row_rel);
                        end
                    end
                end
                DTYPE_ROW_END: begin
                    if (state == ST_ACTIVE) begin
                        row_close = 1'b1;
                        fwd       = !sh_enable || row_in;
                        if (sh_enable) begin
                            fwd_data = '0;
                        end
                    end
                end
                DTYPE_PIXEL: begin
                    if (state == ST_ACTIVE) begin
                        pixel_seen = 1'b1;
                        fwd        = !sh_enable || (row_in && col_in);
                    end
                end
                // Header words and unknown types always pass
                default: begin
                    fwd = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_dtype    <= '0;
            out_data     <= '0;
            sh_enable    <= 1'b0;
            sh_col_start <= '0;
            sh_row_start <= '0;
            sh_num_cols  <= '0;
            sh_num_rows  <= '0;
            row_cnt      <= '0;
            col_cnt      <= '0;
            pix_tally    <= '0;
            row_tally    <= '0;
            last_cols    <= '0;
            rows_out     <= '0;
            cols_out     <= '0;
        end else begin
            out_valid <= fwd;
            out_dtype <= fwd ? strm.dtypei : '0;
            out_data  <= fwd ? fwd_data : '0;

            if (frame_restart) begin
                sh_enable    <= enable;
                sh_col_start <= win_col_start;
                sh_row_start <= win_row_start;
                sh_num_cols  <= win_num_cols;
                sh_num_rows  <= win_num_rows;
                row_cnt      <= '0;
                col_cnt      <= '0;
                pix_tally    <= '0;
                row_tally    <= '0;
                last_cols    <= '0;
            end

            if (frame_close) begin
                rows_out <= row_tally;
                cols_out <= last_cols;
            end

            if (row_open) begin
                col_cnt   <= '0;
                pix_tally <= '0;
            end

            if (pixel_seen) begin
                if (col_cnt != DIM_MAX) begin
                    col_cnt <= col_cnt + DIM_ONE;
                end
                if (fwd && (pix_tally != DIM_MAX)) begin
                    pix_tally <= pix_tally + DIM_ONE;
                end
            end

            if (row_close) begin
                if (row_cnt != DIM_MAX) begin
                    row_cnt <= row_cnt + DIM_ONE;
                end
                pix_tally <= '0;
                if (fwd) begin
                    last_cols <= pix_tally;
                    if (row_tally != DIM_MAX) begin
                        row_tally <= row_tally + DIM_ONE;
                    end
                end
            end
        end
    end

    assign strm.dvo    = out_valid;
    assign strm.dtypeo = out_dtype;
    assign strm.datao  = out_data;

endmodule
`default_nettype wire

// File: tb/tb_image_crop.sv
`default_nettype none
// =============================================================================
// Module   : tb_image_crop
// Brief    : Self-checking bench for image_crop: vector table, directed frames
//            and random frames against a behavioural crop model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_image_crop;

    localparam logic [3:0] FS  = 4'd1;
    localparam logic [3:0] FE  = 4'd2;
    localparam logic [3:0] RS  = 4'd3;
    localparam logic [3:0] RE  = 4'd4;
    localparam logic [3:0] PX  = 4'd5;
    localparam logic [3:0] HS  = 4'd6;
    localparam logic [3:0] HD  = 4'd7;
    localparam logic [3:0] HE  = 4'd8;
    localparam logic [3:0] UNK = 4'hC;

    typedef struct {
        logic        dv;
        logic [3:0]  dt;
        logic [15:0] d;
        logic        edv;
        logic [3:0]  edt;
        logic [15:0] ed;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] wcs, wrs, wnc, wnr;
    logic [15:0] rows_out, cols_out;

    image_crop_if #(.DATA_WIDTH(16), .DTYPE_WIDTH(4)) strm ();

    image_crop #(.DATA_WIDTH(16), .DIM_WIDTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .win_col_start (wcs),
        .win_row_start (wrs),
        .win_num_cols  (wnc),
        .win_num_rows  (wnr),
        .strm          (strm),
        .rows_out      (rows_out),
        .cols_out      (cols_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state (plain integers)
    int m_act, m_en, m_cs, m_rs, m_nc, m_nr;
    int m_row, m_col, m_px, m_rt, m_lc, m_ro, m_co;

    int n_px, n_rs, n_re, n_hdr, n_fs, n_fe, first_rs;
    int frame_no = 0;
    int chg_cs, chg_rs, chg_nc, chg_nr, chg_en;

    vec_t tbl [21];

    function automatic int sat(input int x);
        return (x > 65535) ? 65535 : x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_en = 0; m_cs = 0; m_rs = 0; m_nc = 0; m_nr = 0;
        m_row = 0; m_col = 0; m_px = 0; m_rt = 0; m_lc = 0; m_ro = 0; m_co = 0;
    endtask

    task automatic model(input logic dv, input logic [3:0] dt, input logic [15:0] d,
                         output logic [31:0] e);
        bit fwd;
        bit rin;
        bit cin;
        int od;
        fwd = 0;
        od  = int'(d);
        e   = 32'd0;
        if (!dv) return;
        rin = (m_row >= m_rs) && (m_row < m_rs + m_nr);
        cin = (m_col >= m_cs) && (m_col < m_cs + m_nc);
        case (dt)
            FS: begin
                fwd = 1; m_act = 1; m_en = int'(enable);
                m_cs = int'(wcs); m_rs = int'(wrs); m_nc = int'(wnc); m_nr = int'(wnr);
                m_row = 0; m_col = 0; m_px = 0; m_rt = 0; m_lc = 0;
            end
            FE: if (m_act != 0) begin
                fwd = 1; m_ro = m_rt; m_co = m_lc; m_act = 0;
            end
            RS: if (m_act != 0) begin
                fwd = (m_en == 0) || rin;
                if (m_en != 0) od = m_row - m_rs;
                m_col = 0; m_px = 0;
            end
            RE: if (m_act != 0) begin
                fwd = (m_en == 0) || rin;
                if (m_en != 0) od = 0;
                if (fwd) begin
                    m_rt = sat(m_rt + 1);
                    m_lc = m_px;
                end
                m_px  = 0;
                m_row = sat(m_row + 1);
            end
            PX: if (m_act != 0) begin
                fwd = (m_en == 0) || (rin && cin);
                if (fwd) m_px = sat(m_px + 1);
                m_col = sat(m_col + 1);
            end
            default: fwd = 1;
        endcase
        if (fwd) e = {11'd0, 1'b1, dt, od[15:0]};
    endtask

    task automatic clear_counts();
        n_px = 0; n_rs = 0; n_re = 0; n_hdr = 0; n_fs = 0; n_fe = 0; first_rs = -1;
    endtask

    task automatic step(input logic dv, input logic [3:0] dt, input logic [15:0] d);
        logic [31:0] e;
        strm.dvi    = dv;
        strm.dtypei = dt;
        strm.datai  = d;
        model(dv, dt, d, e);
        @(posedge clk);
        #1;
        check("word", {11'd0, strm.dvo, strm.dtypeo, strm.datao}, e);
        check("status", {rows_out, cols_out}, {m_ro[15:0], m_co[15:0]});
        if (strm.dvo) begin
            case (strm.dtypeo)
                PX: n_px++;
                RS: begin
                    n_rs++;
                    if (first_rs < 0) first_rs = int'(strm.datao);
                end
                RE: n_re++;
                FS: n_fs++;
                FE: n_fe++;
                HS, HD, HE: n_hdr++;
                default: ;
            endcase
        end
    endtask

    task automatic reset_cycle();
        reset       = 1'b1;
        strm.dvi    = 1'b1;
        strm.dtypei = PX;
        strm.datai  = 16'h5A5A;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_word", {11'd0, strm.dvo, strm.dtypeo, strm.datao}, 32'd0);
        check("reset_status", {rows_out, cols_out}, 32'd0);
        clear_counts();
    endtask

    task automatic set_win(input logic [15:0] cs, input logic [15:0] rs,
                           input logic [15:0] nc, input logic [15:0] nr, input logic en);
        wcs = cs; wrs = rs; wnc = nc; wnr = nr; enable = en;
    endtask

    task automatic maybe_idle(input int pct);
        if (int'($urandom_range(99)) < pct)
            step(1'b0, 4'($urandom), 16'($urandom));
    endtask

    task automatic send_frame(input int nc, input int nr, input bit skip_rs0, input bit skip_re_last,
                              input int idle_pct, input int chg_row, input int rst_row);
        step(1'b1, FS, 16'(frame_no));
        frame_no++;
        step(1'b1, HS, 16'hA001);
        step(1'b1, HD, 16'(frame_no * 3));
        step(1'b1, HE, 16'hA00F);
        for (int r = 0; r < nr; r++) begin
            if (r == chg_row)
                set_win(16'(chg_cs), 16'(chg_rs), 16'(chg_nc), 16'(chg_nr), chg_en[0]);
            if (!(skip_rs0 && r == 0)) step(1'b1, RS, 16'(r));
            maybe_idle(idle_pct);
            for (int c = 0; c < nc; c++) begin
                if (r == rst_row && c == 3) begin
                    reset_cycle();
                    step(1'b1, HD, 16'hBEEF);
                end
                step(1'b1, PX, 16'((r << 8) | c));
                maybe_idle(idle_pct);
            end
            if (!(skip_re_last && r == nr - 1)) step(1'b1, RE, 16'hFFFF);
        end
        step(1'b1, FE, 16'h00E0);
    endtask

    function automatic logic [15:0] rnd_start();
        if ($urandom_range(9) == 0) return 16'hFFF0 + 16'($urandom_range(15));
        return 16'($urandom_range(12));
    endfunction

    initial begin
        reset = 1'b1;
        strm.dvi = 1'b0; strm.dtypei = '0; strm.datai = '0;
        set_win(16'd0, 16'd0, 16'd0, 16'd0, 1'b1);
        chg_cs = 0; chg_rs = 0; chg_nc = 2; chg_nr = 2; chg_en = 1;
        model_reset();
        clear_counts();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_word", {11'd0, strm.dvo, strm.dtypeo, strm.datao}, 32'd0);
        check("reset_status", {rows_out, cols_out}, 32'd0);

        // IDLE filtering, then a short cropped frame (window col 2, row 1, 4x3)
        tbl[0]  = '{1'b1, PX,  16'h1234, 1'b0, 4'd0, 16'h0000};
        tbl[1]  = '{1'b1, RS,  16'h0005, 1'b0, 4'd0, 16'h0000};
        tbl[2]  = '{1'b1, RE,  16'h0007, 1'b0, 4'd0, 16'h0000};
        tbl[3]  = '{1'b1, FE,  16'h0009, 1'b0, 4'd0, 16'h0000};
        tbl[4]  = '{1'b1, HS,  16'hAAAA, 1'b1, HS,   16'hAAAA};
        tbl[5]  = '{1'b1, HD,  16'h5555, 1'b1, HD,   16'h5555};
        tbl[6]  = '{1'b1, HE,  16'h0001, 1'b1, HE,   16'h0001};
        tbl[7]  = '{1'b1, UNK, 16'hBEEF, 1'b1, UNK,  16'hBEEF};
        tbl[8]  = '{1'b0, HD,  16'hFFFF, 1'b0, 4'd0, 16'h0000};
        tbl[9]  = '{1'b1, FS,  16'h0007, 1'b1, FS,   16'h0007};
        tbl[10] = '{1'b1, RS,  16'h0000, 1'b0, 4'd0, 16'h0000};
        tbl[11] = '{1'b1, PX,  16'h0011, 1'b0, 4'd0, 16'h0000};
        tbl[12] = '{1'b1, RE,  16'h0000, 1'b0, 4'd0, 16'h0000};
        tbl[13] = '{1'b1, RS,  16'h0099, 1'b1, RS,   16'h0000};
        tbl[14] = '{1'b1, PX,  16'h000A, 1'b0, 4'd0, 16'h0000};
        tbl[15] = '{1'b1, PX,  16'h000B, 1'b0, 4'd0, 16'h0000};
        tbl[16] = '{1'b1, PX,  16'h000C, 1'b1, PX,   16'h000C};
        tbl[17] = '{1'b1, HD,  16'h0003, 1'b1, HD,   16'h0003};
        tbl[18] = '{1'b1, RE,  16'h0055, 1'b1, RE,   16'h0000};
        tbl[19] = '{1'b0, PX,  16'h0123, 1'b0, 4'd0, 16'h0000};
        tbl[20] = '{1'b1, FE,  16'h0000, 1'b1, FE,   16'h0000};
        set_win(16'd2, 16'd1, 16'd4, 16'd3, 1'b1);
        for (int i = 0; i < 21; i++) begin
            step(tbl[i].dv, tbl[i].dt, tbl[i].d);
            check($sformatf("tbl%0d", i), {11'd0, strm.dvo, strm.dtypeo, strm.datao},
                  {11'd0, tbl[i].edv, tbl[i].edt, tbl[i].ed});
        end
        check("tbl_status", {rows_out, cols_out}, {16'd1, 16'd1});

        // Basic crop
        clear_counts();
        send_frame(8, 6, 0, 0, 0, -1, -1);
        check("crop_px", n_px, 12);
        check("crop_rs", n_rs, 3);
        check("crop_re", n_re, 3);
        check("crop_status", {rows_out, cols_out}, {16'd3, 16'd4});

        // Bypass
        set_win(16'd2, 16'd1, 16'd4, 16'd3, 1'b0);
        clear_counts();
        send_frame(8, 6, 0, 0, 0, -1, -1);
        check("byp_px", n_px, 48);
        check("byp_rs", n_rs, 6);
        check("byp_status", {rows_out, cols_out}, {16'd6, 16'd8});

        // Mid-frame reprogram during row 3
        set_win(16'd2, 16'd1, 16'd4, 16'd3, 1'b1);
        chg_cs = 0; chg_rs = 0; chg_nc = 2; chg_nr = 2; chg_en = 1;
        clear_counts();
        send_frame(8, 6, 0, 0, 0, 3, -1);
        check("reprog_cur_px", n_px, 12);
        clear_counts();
        send_frame(8, 6, 0, 0, 0, -1, -1);
        check("reprog_next_px", n_px, 4);
        check("reprog_status", {rows_out, cols_out}, {16'd2, 16'd2});

        // Reset during row 2, then a clean frame
        set_win(16'd2, 16'd1, 16'd4, 16'd3, 1'b1);
        send_frame(8, 6, 0, 0, 0, -1, 2);
        check("rst_px", n_px, 0);
        check("rst_markers", n_rs + n_re + n_fe, 0);
        check("rst_hdr", n_hdr, 1);
        check("rst_status", {rows_out, cols_out}, 32'd0);
        clear_counts();
        send_frame(8, 6, 0, 0, 0, -1, -1);
        check("rst_next_px", n_px, 12);
        check("rst_next_status", {rows_out, cols_out}, {16'd3, 16'd4});

        // Empty window
        set_win(16'd0, 16'd0, 16'd0, 16'd0, 1'b1);
        clear_counts();
        send_frame(8, 6, 0, 0, 0, -1, -1);
        check("empty_rows", n_px + n_rs + n_re, 0);
        check("empty_frame", {8'(n_fs), 8'(n_fe), 16'(n_hdr)}, {8'd1, 8'd1, 16'd3});
        check("empty_status", {rows_out, cols_out}, 32'd0);

        // Column window near the top of the counter range
        set_win(16'hFFFE, 16'd0, 16'h0004, 16'd6, 1'b1);
        clear_counts();
        send_frame(8, 6, 0, 0, 0, -1, -1);
        check("wrap_px", n_px, 0);
        check("wrap_status", {rows_out, cols_out}, {16'd6, 16'd0});

        // Missing first ROW_START with window covering row 0
        set_win(16'd0, 16'd0, 16'd8, 16'd6, 1'b1);
        clear_counts();
        send_frame(8, 6, 1, 0, 0, -1, -1);
        check("miss_px", n_px, 48);
        check("miss_rs", n_rs, 5);
        check("miss_first_rs", first_rs, 1);

        // Window starting beyond the frame
        set_win(16'd0, 16'd100, 16'd8, 16'd5, 1'b1);
        clear_counts();
        send_frame(8, 6, 0, 0, 0, -1, -1);
        check("beyond_rows", n_px + n_rs + n_re, 0);
        check("beyond_status", {rows_out, cols_out}, 32'd0);

        // Random frames
        for (int f = 0; f < 40; f++) begin
            set_win(rnd_start(), rnd_start(), 16'($urandom_range(12)), 16'($urandom_range(10)),
                    ($urandom_range(3) != 0));
            chg_cs = int'(rnd_start()); chg_rs = int'(rnd_start());
            chg_nc = int'($urandom_range(12)); chg_nr = int'($urandom_range(10));
            chg_en = int'($urandom_range(1));
            if ($urandom_range(7) == 0) step(1'b1, PX, 16'($urandom));
            send_frame(int'($urandom_range(12, 1)), int'($urandom_range(10, 1)),
                       ($urandom_range(3) == 0), ($urandom_range(3) == 0),
                       int'($urandom_range(30)),
                       ($urandom_range(1) == 1) ? int'($urandom_range(9)) : -1,
                       ($urandom_range(9) == 0) ? int'($urandom_range(3)) : -1);
            maybe_idle(50);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
